// File: rtl/shift_phase_timer.sv
// shift_phase_timer: multi-phase cycle sequencer (clk/rst/start/abort/hold/repeat_en/phase_len in; busy/phase_idx/count_out/phase_done/all_done out)
module shift_phase_timer #(
  parameter int CNT_W      = 5,
  parameter int NUM_PHASES = 2,
  parameter int PH_W       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        hold,
  input  logic                        repeat_en,
  input  logic [NUM_PHASES*CNT_W-1:0] phase_len,
  output logic                        busy,
  output logic [PH_W-1:0]             phase_idx,
  output logic [CNT_W-1:0]            count_out,
  output logic [NUM_PHASES-1:0]       phase_done,
  output logic                        all_done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                      state_q;
  logic                        busy_q, all_done_q;
  logic [PH_W-1:0]             phase_q, phase_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d, cur_len, last_cnt;
  logic [NUM_PHASES-1:0]       phase_done_q;
  logic [NUM_PHASES*CNT_W-1:0] len_q;
  logic                        at_end, last_ph;
  always_comb begin
    cur_len  = len_q[phase_q*CNT_W +: CNT_W];
    last_cnt = (cur_len == '0) ? '0 : cur_len - CNT_W'(1);
    at_end   = cnt_q == last_cnt;
    last_ph  = phase_q == PH_W'(NUM_PHASES - 1);
    cnt_d    = at_end ? '0 : cnt_q + CNT_W'(1);
    phase_d  = !at_end ? phase_q : last_ph ? '0 : phase_q + PH_W'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      phase_q      <= '0;
      cnt_q        <= '0;
      phase_done_q <= '0;
      all_done_q   <= 1'b0;
      len_q        <= '0;
    end else begin
      phase_done_q <= '0;
      all_done_q   <= 1'b0;
      if (state_q == IDLE) begin
        if (start && !abort) begin
          len_q   <= phase_len;
          state_q <= RUN;
          busy_q  <= 1'b1;
          phase_q <= '0;
          cnt_q   <= '0;
        end
      end else if (abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        phase_q <= '0;
        cnt_q   <= '0;
      end else if (!hold) begin
        cnt_q   <= cnt_d;
        phase_q <= phase_d;
        if (at_end) begin
          phase_done_q <= NUM_PHASES'(1) << phase_q;
          if (last_ph) begin
            all_done_q <= 1'b1;
            if (!repeat_en) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
      end
    end
  end
  assign busy       = busy_q;
  assign phase_idx  = phase_q;
  assign count_out  = cnt_q;
  assign phase_done = phase_done_q;
  assign all_done   = all_done_q;
endmodule

// File: tb/tb_shift_phase_timer.sv
// tb_shift_phase_timer: directed and random checks of shift_phase_timer against an elapsed-time model
module tb_shift_phase_timer;
  localparam int CNT_W = 5;
  localparam int NP    = 2;
  localparam int PH_W  = 1;
  logic clk = 0, rst = 1, start = 0, abort = 0, hold = 0, repeat_en = 0;
  logic [NP*CNT_W-1:0] phase_len = '0;
  logic busy, all_done;
  logic [PH_W-1:0] phase_idx;
  logic [CNT_W-1:0] count_out;
  logic [NP-1:0] phase_done;
  int n_chk = 0, n_fail = 0;
  shift_phase_timer #(.CNT_W(CNT_W), .NUM_PHASES(NP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .repeat_en(repeat_en), .phase_len(phase_len), .busy(busy),
    .phase_idx(phase_idx), .count_out(count_out), .phase_done(phase_done),
    .all_done(all_done)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  int m_snap[NP];
  int m_t = 0;
  bit m_busy = 0, m_all = 0;
  logic [NP-1:0] m_pd = '0;
  function automatic int lp(int p);
    return (m_snap[p] == 0) ? 1 : m_snap[p];
  endfunction
  function automatic int pre(int p);
    int s = 0;
    for (int i = 0; i < p; i++) s += lp(i);
    return s;
  endfunction
  function automatic int e_idx();
    if (!m_busy) return 0;
    for (int p = 0; p < NP; p++) if (m_t < pre(p + 1)) return p;
    return 0;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_t = 0; m_pd = '0; m_all = 0;
      for (int p = 0; p < NP; p++) m_snap[p] = 0;
    end else begin
      m_pd = '0;
      m_all = 0;
      if (!m_busy) begin
        if (start && !abort) begin
          for (int p = 0; p < NP; p++) m_snap[p] = int'(phase_len[p*CNT_W +: CNT_W]);
          m_busy = 1;
          m_t = 0;
        end
      end else if (abort) begin
        m_busy = 0;
        m_t = 0;
      end else if (!hold) begin
        m_t++;
        for (int p = 0; p < NP; p++) if (m_t == pre(p + 1)) m_pd[p] = 1'b1;
        if (m_t == pre(NP)) begin
          m_all = 1;
          m_t = 0;
          if (!repeat_en) m_busy = 0;
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("phase_idx", phase_idx, e_idx());
    chk("count_out", count_out, m_busy ? m_t - pre(e_idx()) : 0);
    chk("phase_done", phase_done, m_pd);
    chk("all_done", all_done, m_all);
  end
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic go(logic [CNT_W-1:0] l0, logic [CNT_W-1:0] l1);
    phase_len = {l1, l0};
    start = 1;
    step(1);
    start = 0;
  endtask
  task automatic scen_basic();
    go(8, 16);
    chk("s1_start_busy", busy, 1);
    step(8);
    chk("s1_pd0", phase_done, 2'b01);
    chk("s1_idx1", phase_idx, 1);
    step(16);
    chk("s1_pd1", phase_done, 2'b10);
    chk("s1_all", all_done, 1);
    chk("s1_busy_off", busy, 0);
    step(3);
  endtask
  initial begin
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", count_out, 0);
    rst = 0;
    step(2);
    scen_basic();
    go(8, 16);
    step(2);
    hold = 1;
    step(3);
    chk("s2_frozen_cnt", count_out, 2);
    hold = 0;
    step(6);
    chk("s2_pd0", phase_done, 2'b01);
    step(16);
    chk("s2_all", all_done, 1);
    step(3);
    go(8, 16);
    step(13);
    chk("s3_pre_idx", phase_idx, 1);
    chk("s3_pre_cnt", count_out, 5);
    abort = 1;
    step(1);
    abort = 0;
    chk("s3_busy", busy, 0);
    chk("s3_cnt", count_out, 0);
    step(30);
    repeat_en = 1;
    go(2, 3);
    step(5);
    chk("s4_all1", all_done, 1);
    chk("s4_busy", busy, 1);
    chk("s4_idx", phase_idx, 0);
    repeat_en = 0;
    step(5);
    chk("s4_all2", all_done, 1);
    chk("s4_end", busy, 0);
    step(3);
    go(0, 31);
    step(1);
    chk("s5_pd0", phase_done, 2'b01);
    chk("s5_idx", phase_idx, 1);
    step(4);
    start = 1;
    phase_len = {5'd3, 5'd2};
    step(1);
    start = 0;
    step(25);
    chk("s5_cnt30", count_out, 30);
    step(1);
    chk("s5_all", all_done, 1);
    chk("s5_busy", busy, 0);
    step(3);
    go(8, 16);
    step(4);
    #2 rst = 1;
    #1;
    chk("s6_busy", busy, 0);
    chk("s6_cnt", count_out, 0);
    chk("s6_idx", phase_idx, 0);
    step(1);
    rst = 0;
    step(1);
    scen_basic();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 29) == 0);
      hold = ($urandom_range(0, 5) == 0);
      repeat_en = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0)
        phase_len = ($urandom_range(0, 3) == 0) ? NP*CNT_W'($urandom) : {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
      step(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
